id_ex_pipeline_reg: RTL and testbench
=====================================

ID_EX_PIPELINE_REG -- requirements
Module: id_ex_pipeline_reg

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 ID_VALID  in  1  decode stage holds a live instruction.
REQ-004 ID_PC  in  32  PC of decoded instruction.
REQ-005 ID_RS1_ADDR  in  5  source register 1 index.
REQ-006 ID_RS2_ADDR  in  5  source register 2 index.
REQ-007 ID_RD_ADDR  in  5  destination register index.
REQ-008 ID_DATA1  in  32  register-file read data 1.
REQ-009 ID_DATA2  in  32  register-file read data 2.
REQ-010 ID_IMM  in  32  sign-extended immediate.
REQ-011 ID_FUNC3  in  3  instruction funct3.
REQ-012 ID_FUNC7  in  7  instruction funct7.
REQ-013 ID_CTRL  in  8  decode controls, bit7..0 = WRITE_ENABLE, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT, JAL_SELECT, DATA_MEM_SELECT.
REQ-014 ID_ALU_OP  in  3  decode ALU operation class.
REQ-015 FLUSH  in  1  taken branch/jump resolved in EX; squash the instruction entering EX.
REQ-016 EX_VALID, EX_PC, EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR, EX_DATA1, EX_DATA2, EX_IMM, EX_FUNC3, EX_FUNC7, EX_CTRL, EX_ALU_OP  out  widths as ID_ counterparts  registered EX-stage copies.
REQ-017 LOAD_USE_STALL  out  1  combinational; freeze PC and IF/ID register this cycle.
REQ-018 BUBBLE_COUNT  out  16  saturating count of inserted bubbles.

Function
REQ-019 Hazard = EX_VALID & EX_CTRL[5] (MEM_READ) & ID_VALID & (EX_RD_ADDR != 0) & (EX_RD_ADDR == ID_RS1_ADDR | EX_RD_ADDR == ID_RS2_ADDR).
REQ-020 LOAD_USE_STALL = Hazard & ~FLUSH, purely combinational, no registered delay.
REQ-021 Per-edge priority: FLUSH > Hazard > normal load.
REQ-022 FLUSH=1: next EX_VALID=0, EX_CTRL=0, EX_ALU_OP=0; data fields don't-care (implementation loads them).
REQ-023 Hazard & ~FLUSH: bubble, same clearing as REQ-022; BUBBLE_COUNT increments by 1.
REQ-024 Otherwise: every EX_ field loads its ID_ counterpart; EX_VALID loads ID_VALID.
REQ-025 ID_VALID=0 on normal load: EX_CTRL and EX_ALU_OP forced to 0 regardless of inputs.
REQ-026 EX_CTRL and EX_ALU_OP are 0 whenever EX_VALID=0; no write or memory side effect can leave a non-valid slot.
REQ-027 Latency: one cycle ID to EX; a stalled instruction enters EX on the edge after LOAD_USE_STALL falls.
REQ-028 Load-use stall lasts exactly one cycle: the bubble clears EX_VALID, so Hazard is 0 next cycle.
REQ-029 Register x0 never causes a hazard, even when EX is a load with rd=0.
REQ-030 BUBBLE_COUNT saturates at 16'hFFFF; FLUSH does not increment it.

Reset
REQ-031 RESET_N low: immediately, asynchronously, all EX_ outputs and BUBBLE_COUNT = 0; LOAD_USE_STALL therefore 0.
REQ-032 Reset deassertion is synchronised externally; the first edge after release performs a normal load.
REQ-033 Reset mid-stall discards the pending bubble and count update.

Verification
REQ-034 Load-use: EX = LW, rd=5, valid; ID = ADD, rs1=5, valid -> LOAD_USE_STALL=1 same cycle; next edge EX_VALID=0, EX_CTRL=0, BUBBLE_COUNT=1; following edge ADD enters EX, stall 0.
REQ-035 rd=x0: EX = LW, rd=0; ID rs2=0 -> LOAD_USE_STALL=0, ID loads normally.
REQ-036 Flush beats hazard: Hazard true and FLUSH=1 -> LOAD_USE_STALL=0; next EX_VALID=0, BUBBLE_COUNT unchanged.
REQ-037 Pass-through: ID_PC=32'h0000_0100, ID_IMM=32'hFFFF_FFF0, ID_CTRL=8'b1000_0000, ID_ALU_OP=3'b011 -> next edge identical EX_ values, EX_VALID=1.
REQ-038 Saturation: preload BUBBLE_COUNT to 16'hFFFE, force two bubbles -> 16'hFFFF and holds.
REQ-039 Async reset: RESET_N low between edges mid-pipeline -> all outputs 0 before the next rising CLK.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing and a
// saturating bubble counter. EX-stage outputs are the registered decode fields.
module id_ex_pipeline_reg (
    input  logic        CLK,
    input  logic        RESET_N,

    input  logic        ID_VALID,
    input  logic [31:0] ID_PC,
    input  logic [4:0]  ID_RS1_ADDR,
    input  logic [4:0]  ID_RS2_ADDR,
    input  logic [4:0]  ID_RD_ADDR,
    input  logic [31:0] ID_DATA1,
    input  logic [31:0] ID_DATA2,
    input  logic [31:0] ID_IMM,
    input  logic [2:0]  ID_FUNC3,
    input  logic [6:0]  ID_FUNC7,
    input  logic [7:0]  ID_CTRL,
    input  logic [2:0]  ID_ALU_OP,
    input  logic        FLUSH,

    output logic        EX_VALID,
    output logic [31:0] EX_PC,
    output logic [4:0]  EX_RS1_ADDR,
    output logic [4:0]  EX_RS2_ADDR,
    output logic [4:0]  EX_RD_ADDR,
    output logic [31:0] EX_DATA1,
    output logic [31:0] EX_DATA2,
    output logic [31:0] EX_IMM,
    output logic [2:0]  EX_FUNC3,
    output logic [6:0]  EX_FUNC7,
    output logic [7:0]  EX_CTRL,
    output logic [2:0]  EX_ALU_OP,

    output logic        LOAD_USE_STALL,
    output logic [15:0] BUBBLE_COUNT
);

    localparam int unsigned CTRL_MEM_READ = 5;
    localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

    logic        ex_valid_q,    ex_valid_d;
    logic [31:0] ex_pc_q,       ex_pc_d;
    logic [4:0]  ex_rs1_addr_q, ex_rs1_addr_d;
    logic [4:0]  ex_rs2_addr_q, ex_rs2_addr_d;
    logic [4:0]  ex_rd_addr_q,  ex_rd_addr_d;
    logic [31:0] ex_data1_q,    ex_data1_d;
    logic [31:0] ex_data2_q,    ex_data2_d;
    logic [31:0] ex_imm_q,      ex_imm_d;
    logic [2:0]  ex_func3_q,    ex_func3_d;
    logic [6:0]  ex_func7_q,    ex_func7_d;
    logic [7:0]  ex_ctrl_q,     ex_ctrl_d;
    logic [2:0]  ex_alu_op_q,   ex_alu_op_d;
    logic [15:0] bubble_count_q, bubble_count_d;

    logic ex_is_load;
    logic rd_nonzero;
    logic src_match;
    logic hazard;
    logic stall;
    logic kill_slot;

    // A load in EX whose destination is read by the live instruction in ID.
    // x0 is excluded since it never carries a real dependency.
    always_comb begin
        ex_is_load = ex_valid_q & ex_ctrl_q[CTRL_MEM_READ];
        rd_nonzero = (ex_rd_addr_q != 5'd0);
        src_match  = (ex_rd_addr_q == ID_RS1_ADDR) | (ex_rd_addr_q == ID_RS2_ADDR);
        hazard     = ex_is_load & ID_VALID & rd_nonzero & src_match;
        stall      = hazard & ~FLUSH;
        kill_slot  = FLUSH | hazard;
    end

    always_comb begin
        // Data fields always load; they are meaningless whenever the slot is not valid.
        ex_pc_d       = ID_PC;
        ex_rs1_addr_d = ID_RS1_ADDR;
        ex_rs2_addr_d = ID_RS2_ADDR;
        ex_rd_addr_d  = ID_RD_ADDR;
        ex_data1_d    = ID_DATA1;
        ex_data2_d    = ID_DATA2;
        ex_imm_d      = ID_IMM;
        ex_func3_d    = ID_FUNC3;
        ex_func7_d    = ID_FUNC7;
        ex_valid_d    = ID_VALID;
        ex_ctrl_d     = ID_VALID ? ID_CTRL   : 8'd0;
        ex_alu_op_d   = ID_VALID ? ID_ALU_OP : 3'd0;

        // Flush and bubble both squash the slot so no side effect can escape it.
        if (kill_slot) begin
            ex_valid_d  = 1'b0;
            ex_ctrl_d   = 8'd0;
            ex_alu_op_d = 3'd0;
        end

        bubble_count_d = bubble_count_q;
        if (stall && (bubble_count_q != COUNT_MAX)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= 32'd0;
            ex_rs1_addr_q  <= 5'd0;
            ex_rs2_addr_q  <= 5'd0;
            ex_rd_addr_q   <= 5'd0;
            ex_data1_q     <= 32'd0;
            ex_data2_q     <= 32'd0;
            ex_imm_q       <= 32'd0;
            ex_func3_q     <= 3'd0;
            ex_func7_q     <= 7'd0;
            ex_ctrl_q      <= 8'd0;
            ex_alu_op_q    <= 3'd0;
            bubble_count_q <= 16'd0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_rs1_addr_q  <= ex_rs1_addr_d;
            ex_rs2_addr_q  <= ex_rs2_addr_d;
            ex_rd_addr_q   <= ex_rd_addr_d;
            ex_data1_q     <= ex_data1_d;
            ex_data2_q     <= ex_data2_d;
            ex_imm_q       <= ex_imm_d;
            ex_func3_q     <= ex_func3_d;
            ex_func7_q     <= ex_func7_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_alu_op_q    <= ex_alu_op_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign EX_VALID       = ex_valid_q;
    assign EX_PC          = ex_pc_q;
    assign EX_RS1_ADDR    = ex_rs1_addr_q;
    assign EX_RS2_ADDR    = ex_rs2_addr_q;
    assign EX_RD_ADDR     = ex_rd_addr_q;
    assign EX_DATA1       = ex_data1_q;
    assign EX_DATA2       = ex_data2_q;
    assign EX_IMM         = ex_imm_q;
    assign EX_FUNC3       = ex_func3_q;
    assign EX_FUNC7       = ex_func7_q;
    assign EX_CTRL        = ex_ctrl_q;
    assign EX_ALU_OP      = ex_alu_op_q;
    assign LOAD_USE_STALL = stall;
    assign BUBBLE_COUNT   = bubble_count_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: a table of hand-computed vectors applied
// back to back, then hand-written reset and saturation sequences.
module tb_id_ex_pipeline_reg;

    logic        CLK;
    logic        RESET_N;
    logic        ID_VALID;
    logic [31:0] ID_PC;
    logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
    logic [31:0] ID_DATA1, ID_DATA2, ID_IMM;
    logic [2:0]  ID_FUNC3;
    logic [6:0]  ID_FUNC7;
    logic [7:0]  ID_CTRL;
    logic [2:0]  ID_ALU_OP;
    logic        FLUSH;
    logic        EX_VALID;
    logic [31:0] EX_PC;
    logic [4:0]  EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR;
    logic [31:0] EX_DATA1, EX_DATA2, EX_IMM;
    logic [2:0]  EX_FUNC3;
    logic [6:0]  EX_FUNC7;
    logic [7:0]  EX_CTRL;
    logic [2:0]  EX_ALU_OP;
    logic        LOAD_USE_STALL;
    logic [15:0] BUBBLE_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_pipeline_reg dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
        .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_IMM(ID_IMM),
        .ID_FUNC3(ID_FUNC3), .ID_FUNC7(ID_FUNC7), .ID_CTRL(ID_CTRL), .ID_ALU_OP(ID_ALU_OP),
        .FLUSH(FLUSH),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .EX_RS1_ADDR(EX_RS1_ADDR), .EX_RS2_ADDR(EX_RS2_ADDR), .EX_RD_ADDR(EX_RD_ADDR),
        .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2), .EX_IMM(EX_IMM),
        .EX_FUNC3(EX_FUNC3), .EX_FUNC7(EX_FUNC7), .EX_CTRL(EX_CTRL), .EX_ALU_OP(EX_ALU_OP),
        .LOAD_USE_STALL(LOAD_USE_STALL), .BUBBLE_COUNT(BUBBLE_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic [2:0]  alu;
        logic        flush;
        logic        exp_stall;
        logic        exp_valid;
        logic [7:0]  exp_ctrl;
        logic [2:0]  exp_alu;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam logic [7:0] C_ALU   = 8'b1000_0000;
    localparam logic [7:0] C_LOAD  = 8'b1010_0001;
    localparam logic [7:0] C_STORE = 8'b0100_0000;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [7:0] ctrl, input logic [2:0] alu, input logic flush);
        ID_VALID    = valid;
        ID_PC       = pc;
        ID_RS1_ADDR = rs1;
        ID_RS2_ADDR = rs2;
        ID_RD_ADDR  = rd;
        ID_DATA1    = {pc[15:0], 16'h1111};
        ID_DATA2    = {16'h2222, pc[15:0]};
        ID_IMM      = imm;
        ID_FUNC3    = pc[4:2];
        ID_FUNC7    = {2'b01, rd};
        ID_CTRL     = ctrl;
        ID_ALU_OP   = alu;
        FLUSH       = flush;
    endtask

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl,
                                input logic [2:0] alu, input logic flush, input logic exp_stall,
                                input logic exp_valid, input logic [7:0] exp_ctrl,
                                input logic [2:0] exp_alu, input logic [15:0] exp_cnt);
        vec_t v;
        v.valid = valid; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.imm = 32'h0000_0040; v.ctrl = ctrl; v.alu = alu; v.flush = flush;
        v.exp_stall = exp_stall; v.exp_valid = exp_valid; v.exp_ctrl = exp_ctrl;
        v.exp_alu = exp_alu; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " EX_VALID"}, {31'd0, EX_VALID}, 32'd0);
        check({tag, " EX_PC"}, EX_PC, 32'd0);
        check({tag, " EX_RD_ADDR"}, {27'd0, EX_RD_ADDR}, 32'd0);
        check({tag, " EX_DATA1"}, EX_DATA1, 32'd0);
        check({tag, " EX_IMM"}, EX_IMM, 32'd0);
        check({tag, " EX_CTRL"}, {24'd0, EX_CTRL}, 32'd0);
        check({tag, " EX_ALU_OP"}, {29'd0, EX_ALU_OP}, 32'd0);
        check({tag, " BUBBLE_COUNT"}, {16'd0, BUBBLE_COUNT}, 32'd0);
        check({tag, " LOAD_USE_STALL"}, {31'd0, LOAD_USE_STALL}, 32'd0);
    endtask

    initial begin
        //          valid pc            rs1 rs2 rd  ctrl     alu fl  stall vld exp_ctrl exp_alu cnt
        vecs[0]  = mk(1, 32'h0000_0100, 1,  2,  3,  C_ALU,   3,  0,  0,    1,  C_ALU,   3,  0);
        vecs[0].imm = 32'hFFFF_FFF0;
        vecs[1]  = mk(1, 32'h0000_0104, 2,  0,  5,  C_LOAD,  0,  0,  0,    1,  C_LOAD,  0,  0);
        vecs[2]  = mk(1, 32'h0000_0108, 5,  6,  7,  C_ALU,   3,  0,  1,    0,  8'h00,   0,  1);
        vecs[3]  = mk(1, 32'h0000_0108, 5,  6,  7,  C_ALU,   3,  0,  0,    1,  C_ALU,   3,  1);
        vecs[4]  = mk(1, 32'h0000_010C, 1,  2,  0,  C_LOAD,  0,  0,  0,    1,  C_LOAD,  0,  1);
        vecs[5]  = mk(1, 32'h0000_0110, 3,  0,  4,  C_ALU,   3,  0,  0,    1,  C_ALU,   3,  1);
        vecs[6]  = mk(1, 32'h0000_0114, 1,  2,  9,  C_LOAD,  0,  0,  0,    1,  C_LOAD,  0,  1);
        vecs[7]  = mk(1, 32'h0000_0118, 1,  9,  10, C_ALU,   2,  1,  0,    0,  8'h00,   0,  1);
        vecs[8]  = mk(0, 32'h0000_011C, 4,  4,  4,  8'hFF,   7,  0,  0,    0,  8'h00,   0,  1);
        vecs[9]  = mk(1, 32'h0000_0120, 1,  2,  12, C_LOAD,  0,  0,  0,    1,  C_LOAD,  0,  1);
        vecs[10] = mk(0, 32'h0000_0124, 12, 0,  1,  C_ALU,   3,  0,  0,    0,  8'h00,   0,  1);
        vecs[11] = mk(1, 32'h0000_0128, 1,  2,  12, C_LOAD,  0,  0,  0,    1,  C_LOAD,  0,  1);
        vecs[12] = mk(1, 32'h0000_012C, 3,  12, 0,  C_STORE, 1,  0,  1,    0,  8'h00,   0,  2);
        vecs[13] = mk(1, 32'h0000_012C, 3,  12, 0,  C_STORE, 1,  0,  0,    1,  C_STORE, 1,  2);
        vecs[14] = mk(1, 32'h0000_0130, 1,  1,  1,  C_ALU,   5,  1,  0,    0,  8'h00,   0,  2);

        RESET_N = 1'b0;
        drive(0, 32'd0, 0, 0, 0, 32'd0, 8'd0, 3'd0, 0);
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RESET_N = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].imm, vecs[i].ctrl, vecs[i].alu, vecs[i].flush);
            #1;
            check($sformatf("v%0d stall", i), {31'd0, LOAD_USE_STALL}, {31'd0, vecs[i].exp_stall});
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("v%0d EX_VALID", i), {31'd0, EX_VALID}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d EX_CTRL", i), {24'd0, EX_CTRL}, {24'd0, vecs[i].exp_ctrl});
            check($sformatf("v%0d EX_ALU_OP", i), {29'd0, EX_ALU_OP}, {29'd0, vecs[i].exp_alu});
            check($sformatf("v%0d BUBBLE_COUNT", i), {16'd0, BUBBLE_COUNT}, {16'd0, vecs[i].exp_cnt});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d EX_PC", i), EX_PC, vecs[i].pc);
                check($sformatf("v%0d EX_RS1", i), {27'd0, EX_RS1_ADDR}, {27'd0, vecs[i].rs1});
                check($sformatf("v%0d EX_RS2", i), {27'd0, EX_RS2_ADDR}, {27'd0, vecs[i].rs2});
                check($sformatf("v%0d EX_RD", i), {27'd0, EX_RD_ADDR}, {27'd0, vecs[i].rd});
                check($sformatf("v%0d EX_IMM", i), EX_IMM, vecs[i].imm);
                check($sformatf("v%0d EX_DATA1", i), EX_DATA1, {vecs[i].pc[15:0], 16'h1111});
                check($sformatf("v%0d EX_DATA2", i), EX_DATA2, {16'h2222, vecs[i].pc[15:0]});
                check($sformatf("v%0d EX_FUNC3", i), {29'd0, EX_FUNC3}, {29'd0, vecs[i].pc[4:2]});
                check($sformatf("v%0d EX_FUNC7", i), {25'd0, EX_FUNC7}, {25'd0, 2'b01, vecs[i].rd});
            end
        end

        // Async reset between edges with a live instruction in EX.
        drive(1, 32'h0000_0200, 1, 2, 3, 32'h55, C_ALU, 3'd3, 0);
        @(posedge CLK);
        #2;
        check("pre-reset EX_VALID", {31'd0, EX_VALID}, 32'd1);
        RESET_N = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge CLK);
        RESET_N = 1'b1;

        // Reset while a stall is pending: bubble and count update are discarded.
        drive(1, 32'h0000_0300, 1, 2, 8, 32'h0, C_LOAD, 3'd0, 0);
        @(posedge CLK);
        @(negedge CLK);
        drive(1, 32'h0000_0304, 8, 2, 9, 32'h0, C_ALU, 3'd3, 0);
        #1;
        check("mid-stall stall", {31'd0, LOAD_USE_STALL}, 32'd1);
        RESET_N = 1'b0;
        #1;
        check("mid-stall reset stall", {31'd0, LOAD_USE_STALL}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check("mid-stall reset count", {16'd0, BUBBLE_COUNT}, 32'd0);
        RESET_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("post-reset load EX_VALID", {31'd0, EX_VALID}, 32'd1);
        check("post-reset load EX_PC", EX_PC, 32'h0000_0304);
        check("post-reset load count", {16'd0, BUBBLE_COUNT}, 32'd0);

        // Saturation: preload the counter, then force two bubbles.
        force dut.bubble_count_q = 16'hFFFE;
        drive(1, 32'h0000_0400, 1, 2, 20, 32'h0, C_LOAD, 3'd0, 0);
        @(posedge CLK);
        @(negedge CLK);
        release dut.bubble_count_q;
        #1;
        check("preload count", {16'd0, BUBBLE_COUNT}, 32'h0000_FFFE);
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h0000_0404, 20, 3, 21, 32'h0, C_ALU, 3'd3, 0);
            #1;
            check($sformatf("sat%0d stall", k), {31'd0, LOAD_USE_STALL}, 32'd1);
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("sat%0d count", k), {16'd0, BUBBLE_COUNT}, 32'h0000_FFFF);
            drive(1, 32'h0000_0408, 1, 2, 20, 32'h0, C_LOAD, 3'd0, 0);
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("sat%0d hold", k), {16'd0, BUBBLE_COUNT}, 32'h0000_FFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
